freddie_dram_bridge: RTL

- Downstream consumer of the Freddie DRAM interface (ras, cas, w, ba).
- Rebuilds the 16-bit CPU address from the multiplexed row/column bytes and issues single-cycle read/write strobes to a synchronous on-chip RAM.
- Classifies RAS-only and CAS-before-RAS refresh cycles and counts them.
- Flags protocol violations for bench and FPGA debug.

---
 rtl/freddie_dram_bridge.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/freddie_dram_bridge.sv
// freddie_dram_bridge: consumes the Freddie DRAM strobes (ras/cas/w/ba),
// rebuilds the 16-bit address from the row/column bytes, issues one-cycle
// read/write strobes to an on-chip RAM, counts RAS-only and CBR refresh
// cycles and flags protocol violations.
// Optional build macro FREDDIE_PAGE_MODE_EN: when defined, further CAS falls
// inside one RAS-low period are page-mode accesses; otherwise they are errors.
module freddie_dram_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ROW_HIGH    = 0,
  parameter int REF_CNT_W   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 w,
  input  logic [7:0]           ba,
  output logic [15:0]          mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [REF_CNT_W-1:0] refresh_cnt,
  output logic                 cbr_seen,
  output logic                 proto_err
);

  // Synchroniser depth outside 1..4 is not supported.
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("freddie_dram_bridge: SYNC_STAGES must be in 1..4");
  end

  // Bundle layout: {ras, cas, w, ba[7:0]}; strobes idle high, address idles 0.
  localparam logic [10:0] SYNC_RST = {3'b111, 8'h00};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW      = 3'd1,
    COL      = 3'd2,
    CBR      = 3'd3,
    CBR_WAIT = 3'd4
  } state_t;

  logic [10:0] sync_q [SYNC_STAGES];
  logic        ras_prev_q;
  logic        cas_prev_q;

  logic        ras_s;
  logic        cas_s;
  logic        w_s;
  logic [7:0]  ba_s;
  logic        ras_fall;
  logic        ras_rise;
  logic        cas_fall;
  logic        cas_rise;

  state_t                 state_q,       state_d;
  logic [7:0]             row_q,         row_d;
  logic                   accessed_q,    accessed_d;
  logic                   lock_q,        lock_d;
  logic [15:0]            mem_addr_q,    mem_addr_d;
  logic                   mem_re_q,      mem_re_d;
  logic                   mem_we_q,      mem_we_d;
  logic [REF_CNT_W-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic                   cbr_seen_q,    cbr_seen_d;
  logic                   proto_err_q,   proto_err_d;

  logic                   do_access;
  logic [7:0]             access_row;

  // All four inputs share one pipeline so they stay mutually aligned.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_RST;
      end
    end else begin
      sync_q[0] <= {ras, cas, w, ba};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ras_s = sync_q[SYNC_STAGES-1][10];
  assign cas_s = sync_q[SYNC_STAGES-1][9];
  assign w_s   = sync_q[SYNC_STAGES-1][8];
  assign ba_s  = sync_q[SYNC_STAGES-1][7:0];

  // Previous synced strobe levels; reset high so no edge fires right after reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ras_prev_q <= 1'b1;
      cas_prev_q <= 1'b1;
    end else begin
      ras_prev_q <= ras_s;
      cas_prev_q <= cas_s;
    end
  end

  assign ras_fall = ras_prev_q & ~ras_s;
  assign ras_rise = ~ras_prev_q & ras_s;
  assign cas_fall = cas_prev_q & ~cas_s;
  assign cas_rise = ~cas_prev_q & cas_s;

  // Next-state and output decode for the DRAM cycle tracker.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    accessed_d    = accessed_q;
    lock_d        = lock_q;
    mem_addr_d    = mem_addr_q;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    refresh_cnt_d = refresh_cnt_q;
    cbr_seen_d    = cbr_seen_q;
    proto_err_d   = proto_err_q;
    do_access     = 1'b0;
    access_row    = row_q;

    case (state_q)
      IDLE: begin
        accessed_d = 1'b0;
        lock_d     = 1'b0;
        if (ras_fall) begin
          // A simultaneous CAS fall is treated as RAS-first: access right away.
          row_d   = ba_s;
          state_d = ROW;
          if (cas_fall) begin
            access_row = ba_s;
            do_access  = 1'b1;
            accessed_d = 1'b1;
            state_d    = COL;
          end
        end else if (cas_fall) begin
          state_d = CBR;
        end
      end

      ROW: begin
        if (ras_rise) begin
          // Only a RAS pulse with no column access counts as RAS-only refresh.
          if (!accessed_q) begin
            refresh_cnt_d = refresh_cnt_q + REF_CNT_W'(1);
          end
          state_d = IDLE;
        end else if (cas_fall) begin
          state_d = COL;
          if (!accessed_q) begin
            do_access  = 1'b1;
            accessed_d = 1'b1;
          end else begin
`ifdef FREDDIE_PAGE_MODE_EN
            do_access = 1'b1;
`else
            proto_err_d = 1'b1;
            lock_d      = 1'b1;
`endif
          end
        end
      end

      COL: begin
        // RAS rise wins over a simultaneous CAS rise; lock pins us here after a bad page access.
        if (ras_rise) begin
          state_d = IDLE;
        end else if (cas_rise && !lock_q) begin
          state_d = ROW;
        end
      end

      CBR: begin
        if (ras_fall) begin
          refresh_cnt_d = refresh_cnt_q + REF_CNT_W'(1);
          cbr_seen_d    = 1'b1;
          state_d       = CBR_WAIT;
        end else if (cas_rise) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end
      end

      CBR_WAIT: begin
        if (ras_s && cas_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_access) begin
      mem_addr_d = (ROW_HIGH != 0) ? {access_row, ba_s} : {ba_s, access_row};
      mem_we_d   = ~w_s;
      mem_re_d   = w_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      row_q         <= 8'h00;
      accessed_q    <= 1'b0;
      lock_q        <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      refresh_cnt_q <= '0;
      cbr_seen_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      accessed_q    <= accessed_d;
      lock_q        <= lock_d;
      mem_addr_q    <= mem_addr_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      refresh_cnt_q <= refresh_cnt_d;
      cbr_seen_q    <= cbr_seen_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign refresh_cnt = refresh_cnt_q;
  assign cbr_seen    = cbr_seen_q;
  assign proto_err   = proto_err_q;

endmodule
